// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package mem_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE_R,
        DONE_W
    } state_e;

    // Byte address bits below this index are ignored (word-granular store).
    localparam int WORD_LSB = 2;

    function automatic int word_msb(input int aw);
        return aw + WORD_LSB - 1;
    endfunction

    function automatic int cnt_width(input int rd_lat, input int wr_lat);
        int max_lat;
        max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        return $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-bank word store: combinational read, registered write.
module mem_array
    import mem_resp_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle responder for the MR read port and MW write port.
// One access in flight; completion is a one-cycle *_finished pulse.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int AW        = 10,
    parameter int READ_LAT  = 3,
    parameter int WRITE_LAT = 4
) (
    input  logic        clk,
    input  logic        r,
    input  logic        re,
    input  logic [31:0] r_addr,
    output logic [31:0] d_out,
    output logic        r_finished,
    input  logic        we,
    input  logic [31:0] w_addr,
    input  logic [31:0] d_in,
    output logic        w_finished
);

    localparam int CW  = cnt_width(READ_LAT, WRITE_LAT);
    localparam int MSB = word_msb(AW);

    localparam logic [CW-1:0] RD_LOAD = CW'(READ_LAT - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   rdata;
    logic          arr_we;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{r_addr[31:MSB+1], r_addr[WORD_LSB-1:0],
                                w_addr[31:MSB+1], w_addr[WORD_LSB-1:0]};

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        r_finished = 1'b0;
        w_finished = 1'b0;
        d_out      = '0;
        arr_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The MW instruction is older, so a pending write goes first.
                if (we) begin
                    addr_d  = w_addr[MSB:WORD_LSB];
                    data_d  = d_in;
                    cnt_d   = WR_LOAD;
                    state_d = (WRITE_LAT == 1) ? DONE_W : WRITE;
                end else if (re) begin
                    addr_d  = r_addr[MSB:WORD_LSB];
                    cnt_d   = RD_LOAD;
                    state_d = (READ_LAT == 1) ? DONE_R : READ;
                end
            end
            READ: begin
                if (!re) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = DONE_R;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WRITE: begin
                if (!we) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = DONE_W;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE_R: begin
                r_finished = 1'b1;
                d_out      = rdata;
                state_d    = IDLE;
            end
            DONE_W: begin
                // Commit happens on the edge leaving DONE_W.
                w_finished = 1'b1;
                arr_we     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_array #(
        .AW(AW)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .waddr(addr_q),
        .wdata(data_q),
        .raddr(addr_q),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (default latencies plus a
// READ_LAT=1/WRITE_LAT=1 instance).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        r;
    logic        re, we;
    logic [31:0] r_addr, w_addr, d_in;
    logic [31:0] d_out;
    logic        r_finished, w_finished;

    logic        re2, we2;
    logic [31:0] r_addr2, w_addr2, d_in2;
    logic [31:0] d_out2;
    logic        rf2, wf2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk       (clk),
        .r         (r),
        .re        (re),
        .r_addr    (r_addr),
        .d_out     (d_out),
        .r_finished(r_finished),
        .we        (we),
        .w_addr    (w_addr),
        .d_in      (d_in),
        .w_finished(w_finished)
    );

    mem_responder #(
        .AW       (10),
        .READ_LAT (1),
        .WRITE_LAT(1)
    ) dut2 (
        .clk       (clk),
        .r         (r),
        .re        (re2),
        .r_addr    (r_addr2),
        .d_out     (d_out2),
        .r_finished(rf2),
        .we        (we2),
        .w_addr    (w_addr2),
        .d_in      (d_in2),
        .w_finished(wf2)
    );

    // Drives one request on dut; returns completion cycle (-1 on timeout).
    task automatic xfer(input logic is_wr, input logic [31:0] addr,
                        input logic [31:0] data,
                        output int cyc, output logic [31:0] rd);
        cyc = -1;
        rd  = '0;
        if (is_wr) begin
            we = 1'b1; w_addr = addr; d_in = data;
        end else begin
            re = 1'b1; r_addr = addr;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((is_wr ? w_finished : r_finished) === 1'b1) begin
                cyc = c;
                rd  = d_out;
            end
            @(posedge clk);
            #1;
            if (cyc >= 0) break;
        end
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic test_reset();
        r = 1'b1;
        re = 1'b1; we = 1'b1;
        r_addr = 32'h10; w_addr = 32'h10; d_in = 32'h0;
        re2 = 1'b0; we2 = 1'b0;
        r_addr2 = '0; w_addr2 = '0; d_in2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (r_finished !== 1'b0)
            $display("FAIL reset_rf: got %b expected 0", r_finished);
        else passed++;
        total++;
        if (w_finished !== 1'b0)
            $display("FAIL reset_wf: got %b expected 0", w_finished);
        else passed++;
        total++;
        if (d_out !== 32'h0)
            $display("FAIL reset_dout: got %h expected 0", d_out);
        else passed++;
        total++;
        if ({rf2, wf2, d_out2} !== 34'h0)
            $display("FAIL reset_dut2: got %b/%b/%h expected 0/0/0",
                     rf2, wf2, d_out2);
        else passed++;
        re = 1'b0; we = 1'b0;
        @(posedge clk);
        #1;
        r = 1'b0;
    endtask

    task automatic test_preload();
        int cyc;
        logic [31:0] rd;
        xfer(1'b1, 32'h10, 32'd5, cyc, rd);
        total++;
        if (cyc !== 4) $display("FAIL preload_10: cycle %0d expected 4", cyc);
        else passed++;
        xfer(1'b1, 32'h40, 32'h1, cyc, rd);
        total++;
        if (cyc !== 4) $display("FAIL preload_40: cycle %0d expected 4", cyc);
        else passed++;
        xfer(1'b1, 32'h30, 32'h77, cyc, rd);
        total++;
        if (cyc !== 4) $display("FAIL preload_30: cycle %0d expected 4", cyc);
        else passed++;
    endtask

    task automatic test_read();
        re = 1'b1;
        r_addr = 32'h10;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++;
            if (r_finished !== (c == 3))
                $display("FAIL read_rf c%0d: got %b expected %b",
                         c, r_finished, (c == 3));
            else passed++;
            total++;
            if (d_out !== ((c == 3) ? 32'd5 : 32'd0))
                $display("FAIL read_dout c%0d: got %h expected %h",
                         c, d_out, ((c == 3) ? 32'd5 : 32'd0));
            else passed++;
            @(posedge clk);
            #1;
            if (c == 3) re = 1'b0;
        end
    endtask

    task automatic test_write();
        int cyc;
        logic [31:0] rd;
        xfer(1'b1, 32'h20, 32'hDEADBEEF, cyc, rd);
        total++;
        if (cyc !== 4) $display("FAIL write_lat: cycle %0d expected 4", cyc);
        else passed++;
        xfer(1'b0, 32'h20, 32'h0, cyc, rd);
        total++;
        if (cyc !== 3) $display("FAIL wr_read_lat: cycle %0d expected 3", cyc);
        else passed++;
        total++;
        if (rd !== 32'hDEADBEEF)
            $display("FAIL wr_read_data: got %h expected deadbeef", rd);
        else passed++;
        xfer(1'b0, 32'hFFFFF023, 32'h0, cyc, rd);
        total++;
        if (rd !== 32'hDEADBEEF)
            $display("FAIL addr_alias: got %h expected deadbeef", rd);
        else passed++;
    endtask

    task automatic test_simultaneous();
        int wc = -1;
        int rc = -1;
        int both = 0;
        logic [31:0] rd = '0;
        we = 1'b1; re = 1'b1;
        w_addr = 32'h40; r_addr = 32'h40; d_in = 32'h2;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (w_finished === 1'b1 && r_finished === 1'b1) both++;
            if (w_finished === 1'b1) wc = c;
            if (r_finished === 1'b1) begin
                rc = c;
                rd = d_out;
            end
            @(posedge clk);
            #1;
            if (wc == c) we = 1'b0;
            if (rc >= 0) break;
        end
        we = 1'b0; re = 1'b0;
        total++;
        if (wc !== 4) $display("FAIL simul_wc: cycle %0d expected 4", wc);
        else passed++;
        total++;
        if (rc !== 8) $display("FAIL simul_rc: cycle %0d expected 8", rc);
        else passed++;
        total++;
        if (rd !== 32'h2) $display("FAIL simul_data: got %h expected 2", rd);
        else passed++;
        total++;
        if (both !== 0) $display("FAIL simul_both: got %0d expected 0", both);
        else passed++;
    endtask

    task automatic test_abort();
        int seen = 0;
        int cyc;
        logic [31:0] rd;
        we = 1'b1; w_addr = 32'h30; d_in = 32'h55;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (w_finished === 1'b1) seen++;
            @(posedge clk);
            #1;
            if (c == 1) we = 1'b0;
        end
        total++;
        if (seen !== 0) $display("FAIL abort_wf: got %0d pulses expected 0", seen);
        else passed++;
        xfer(1'b0, 32'h30, 32'h0, cyc, rd);
        total++;
        if (cyc !== 3) $display("FAIL abort_rdlat: cycle %0d expected 3", cyc);
        else passed++;
        total++;
        if (rd !== 32'h77) $display("FAIL abort_data: got %h expected 77", rd);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int found = 0;
        int cyc;
        logic [31:0] rd;
        re = 1'b1; r_addr = 32'h10;
        @(posedge clk);
        #2;
        r = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (r_finished === 1'b1) seen++;
            @(posedge clk);
        end
        #1;
        re = 1'b0; r = 1'b0;
        total++;
        if (seen !== 0) $display("FAIL rstmid_rf: got %0d pulses expected 0", seen);
        else passed++;
        xfer(1'b0, 32'h10, 32'h0, cyc, rd);
        total++;
        if (cyc !== 3) $display("FAIL rstmid_lat: cycle %0d expected 3", cyc);
        else passed++;
        total++;
        if (rd !== 32'd5) $display("FAIL rstmid_data: got %h expected 5", rd);
        else passed++;
        we = 1'b1; w_addr = 32'h20; d_in = 32'h1234;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (w_finished === 1'b1) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (found !== 1) $display("FAIL rstw_seen: got %0d expected 1", found);
        else passed++;
        #1;
        r = 1'b1;
        #1;
        total++;
        if (w_finished !== 1'b0)
            $display("FAIL rstw_async: got %b expected 0", w_finished);
        else passed++;
        @(posedge clk);
        #1;
        we = 1'b0; r = 1'b0;
        xfer(1'b0, 32'h20, 32'h0, cyc, rd);
        total++;
        if (rd !== 32'hDEADBEEF)
            $display("FAIL rstw_nowrite: got %h expected deadbeef", rd);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int p[3] = '{-1, -1, -1};
        int n = 0;
        int bad = 0;
        re = 1'b1; r_addr = 32'h40;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (r_finished === 1'b1) begin
                if (n < 3) p[n] = c;
                n++;
                if (d_out !== 32'h2) bad++;
            end
            @(posedge clk);
            #1;
        end
        re = 1'b0;
        total++;
        if (n !== 3) $display("FAIL b2b_count: got %0d expected 3", n);
        else passed++;
        total++;
        if (p[0] !== 3 || p[1] !== 7 || p[2] !== 11)
            $display("FAIL b2b_cycles: got %0d,%0d,%0d expected 3,7,11",
                     p[0], p[1], p[2]);
        else passed++;
        total++;
        if (bad !== 0) $display("FAIL b2b_data: got %0d bad words expected 0", bad);
        else passed++;
    endtask

    task automatic test_lat1();
        we2 = 1'b1; w_addr2 = 32'h8; d_in2 = 32'hA5;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (wf2 !== (c == 1))
                $display("FAIL lat1_wf c%0d: got %b expected %b", c, wf2, (c == 1));
            else passed++;
            @(posedge clk);
            #1;
            if (c == 1) we2 = 1'b0;
        end
        re2 = 1'b1; r_addr2 = 32'h8;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++;
            if (rf2 !== (c % 2 == 1))
                $display("FAIL lat1_rf c%0d: got %b expected %b",
                         c, rf2, (c % 2 == 1));
            else passed++;
            total++;
            if (d_out2 !== ((c % 2 == 1) ? 32'hA5 : 32'h0))
                $display("FAIL lat1_dout c%0d: got %h expected %h",
                         c, d_out2, ((c % 2 == 1) ? 32'hA5 : 32'h0));
            else passed++;
            @(posedge clk);
            #1;
        end
        re2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_preload();
        test_read();
        test_write();
        test_simultaneous();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_lat1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the pipeline's two data-memory ports: the MR-stage read port and the MW-stage write port. It replaces the zero-latency behavioural memory with a single-bank, multi-cycle model. Each request is held by the pipeline until a one-cycle `*_finished` pulse; that pulse is what releases `mr_stall` and `mw_stall`. The block sits beside the MR/MW stages in `TOP` and connects directly to `v_mr_re`/`mr_addr` and `v_mem_we`/`mw_addr`/`mw_aluval`.

## Interface
Parameters:
- AW, 10, word-address width; the backing store holds 2^AW 32-bit words.
- READ_LAT, 3, cycles from read accept to `r_finished`; must be at least 1.
- WRITE_LAT, 4, cycles from write accept to `w_finished`; must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- r  in  1  reset, asynchronous, active-high.
- re  in  1  read request, level; held by the requester until `r_finished`.
- r_addr  in  32  read byte address; bits [AW+1:2] select the word.
- d_out  out  32  read data; valid only in the `r_finished` cycle.
- r_finished  out  1  one-cycle read completion pulse.
- we  in  1  write request, level; held until `w_finished`.
- w_addr  in  32  write byte address; bits [AW+1:2] select the word.
- d_in  in  32  write data.
- w_finished  out  1  one-cycle write completion pulse.

## Operation
- Single bank: at most one access is in flight at a time.
- FSM states:
  - IDLE to WRITE: `we` sampled high. Writes win over reads because the MW instruction is older.
  - IDLE to READ: `re` high and `we` low.
  - READ or WRITE to DONE_R or DONE_W: the latency counter reaches 1.
  - DONE_R or DONE_W to IDLE: unconditional.
- On accept: capture the word address (and `d_in` for a write), and load the counter with LAT−1.
  - If LAT equals 1, go directly to DONE.
- DONE_R: `r_finished` is 1 and `d_out` is the array word at the captured address, read in the DONE cycle.
- DONE_W: `w_finished` is 1 and the array is written on the edge that leaves DONE_W.
- After DONE, the FSM spends at least one cycle in IDLE. A request still high in that IDLE cycle is treated as a new request, because the stage has advanced.
- Abort: if the owning request drops while in READ or WRITE, return to IDLE next edge.
  - No finished pulse is produced.
  - An aborted write never modifies the array.
- Address or data changes mid-access are ignored; the captured copies are used.
- Address bits above AW+1 and bits [1:0] are ignored. There is no alignment fault.
- `d_out` is 0 outside DONE_R.

## Timing
- Reset values: state IDLE, counter 0, `r_finished` 0, `w_finished` 0, `d_out` 0. Array contents are not reset.
- Reset asserted mid-access cancels it: no pulse, and no array write.
- Read latency: `re` high before edge E0 with the FSM idle gives `r_finished` in the cycle after edge E0+READ_LAT−1. With READ_LAT=3, that is cycle 3 counting the request cycle as cycle 0.
- Write latency: same rule with WRITE_LAT. The write commits at the edge ending the `w_finished` cycle.
- Simultaneous `re` and `we` in IDLE: the write is served first. The read is accepted in the IDLE cycle after DONE_W and sees the new data.
- Back-to-back reads occupy READ_LAT+1 cycles per access.
- `r_finished` and `w_finished` are never high in the same cycle.

## Structure
- Package `mem_resp_pkg` holds:
  - the FSM state enum (IDLE, READ, WRITE, DONE_R, DONE_W);
  - the counter width, defined as clog2 of max(READ_LAT, WRITE_LAT)+1;
  - word-index extraction constants.
- Sub-module `mem_array`: 2^AW×32, with asynchronous read port, synchronous write port and write enable. It is the only storage.
- The FSM and counter live in `mem_responder`.

## Test plan
- Reset, then read at 0x10 with `re` held: `r_finished` is pulsed exactly once, in cycle 3; `d_out` equals the preloaded word 5 in that cycle and is 0 otherwise.
- Write 0xDEADBEEF to 0x20, then read 0x20: `w_finished` in cycle 4; the read then returns 0xDEADBEEF.
- `re` and `we` both asserted in the same cycle, both to 0x40 (old value 0x1, new value 0x2): `w_finished` comes first; `r_finished` follows WRITE_LAT+1+READ_LAT cycles after the request and returns 0x2.
- Drop `we` in cycle 2 of a write of 0x55 to 0x30: no `w_finished`; a later read of 0x30 returns the old value.
- Assert `r` mid-read in cycle 1: outputs go to 0 asynchronously and no pulse is produced; after release, a fresh read completes normally.
- With READ_LAT=1, keep `re` high continuously: `r_finished` pulses every 2 cycles.
